rf_writeback_arbiter: RTL and testbench
=======================================

Name: rf_writeback_arbiter

Overview:
- Writer side of the register-file write port. Drives RegWrite / Write_addr / Write_data into the 32x32 regfile.
- Merges two result sources:
  - single-cycle ALU results, which always win arbitration;
  - long-latency MDU/load results, which are buffered in a small FIFO.
- Keeps a pending-write scoreboard (busy_vec) that decode uses to stall on RAW hazards against outstanding long-latency ops.

Parameters:
- DATA_W, 32, result/data width.
- ADDR_W, 5, register address width.
- NREG, 32, number of architectural registers (= 2**ADDR_W).
- Q_DEPTH, 4, MDU result FIFO depth; power of two, at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- alu_valid  input  1  ALU result present this cycle; no backpressure.
- alu_addr  input  ADDR_W  ALU destination register.
- alu_data  input  DATA_W  ALU result.
- mdu_valid  input  1  MDU result offered.
- mdu_ready  output  1  FIFO can accept; transfer happens when mdu_valid && mdu_ready at a rising edge.
- mdu_addr  input  ADDR_W  MDU destination register.
- mdu_data  input  DATA_W  MDU result.
- issue_valid  input  1  decode issued a long-latency op this cycle.
- issue_addr  input  ADDR_W  destination of the issued op.
- busy_vec  output  NREG  bit r = 1 means a long-latency write to r is outstanding.
- RegWrite  output  1  regfile write enable, registered.
- Write_addr  output  ADDR_W  regfile write address, registered.
- Write_data  output  DATA_W  regfile write data, registered.

Behaviour:
- Reset (rst=0, asynchronous):
  - RegWrite=0, Write_addr=0, Write_data=0;
  - FIFO empty, count=0;
  - busy_vec=0;
  - mdu_ready=1 once rst is deasserted.
  - Reset asserted mid-operation discards all queued results and pending bits immediately.
- One regfile write per cycle. Output registers load every rising edge.
- Arbitration each cycle:
  - If alu_valid, select ALU.
  - Else, if FIFO is non-empty, select the FIFO head and pop it.
  - Else, select nothing.
- Output update at the edge:
  - RegWrite <= (selection exists) && (selected addr != 0).
  - Write_addr / Write_data <= selected values. They hold their previous values when nothing is selected.
- Latency:
  - ALU: result at edge N appears with RegWrite=1 in cycle N+1.
  - MDU: accepted at edge N, written at the earliest in cycle N+2 (push, then pop). Each cycle with alu_valid=1 adds one cycle of delay.
- FIFO:
  - In-order.
  - mdu_ready = (count < Q_DEPTH), a function of registered count only.
  - When full, no push occurs in a cycle even if a pop happens in that same cycle.
  - Push and pop in the same cycle when not full: count is unchanged.
  - Pointers wrap modulo Q_DEPTH.
- Register 0:
  - Writes to addr 0 from either source are consumed (FIFO entries still pop) but RegWrite stays 0.
  - busy_vec[0] is never set.
- Scoreboard:
  - issue_valid with issue_addr != 0 sets busy_vec[issue_addr] at the edge.
  - The bit clears at the edge that ends a cycle in which RegWrite=1 and the write originated from the MDU FIFO for that address. This is the same edge on which the regfile captures the data, so a decode read after the clear sees the new value.
  - Simultaneous set and clear of the same bit: set wins (a newer op is pending).
  - ALU writes never modify busy_vec. Decode must not issue an ALU op whose destination is busy (WAW); this is not checked here.
- No other state machine. Behaviour is fully determined by the FIFO count, the pointers and busy_vec.

Decomposition:
- Shared package (core_pkg):
  - DATA_W, ADDR_W, NREG;
  - typedef wb_req_t = {addr[ADDR_W], data[DATA_W]};
  - localparam REG_ZERO = 0.
- Sub-module wb_fifo, parameterised by Q_DEPTH and payload wb_req_t:
  - push, pop, head, count, full, empty;
  - asynchronous active-low reset on pointers and count.
- Arbitration, output registers and scoreboard stay in rf_writeback_arbiter.

Test Plan:
- ALU-only stream: alu_valid=1 with (3, 0x11), then (4, 0x22) in consecutive cycles → RegWrite=1 with Write_addr 3 / data 0x11, then 4 / 0x22, each one cycle later; busy_vec stays 0.
- Scoreboard round trip: issue_addr=5 → busy_vec[5]=1. Then MDU (5, 0xDEAD) accepted at edge N with no ALU traffic → RegWrite=1, addr 5 in cycle N+2; busy_vec[5]=0 from cycle N+3.
- Priority and backpressure: hold alu_valid=1 for 6 cycles while offering 5 MDU results →
  - mdu_ready drops to 0 after 4 accepts;
  - the 5th is accepted only after the first pop;
  - the MDU writes then drain in order 1–5 once alu_valid falls.
- Register 0: ALU (0, 0xFFFF) and MDU (0, 0x1234); issue_addr=0 → RegWrite never asserted, FIFO count returns to 0, busy_vec[0]=0.
- Set/clear collision: MDU write to 7 clearing busy_vec[7] in the same cycle that issue_addr=7 → busy_vec[7] remains 1.
- Reset mid-operation: FIFO holding 3 entries and busy_vec=0x000000A0, pulse rst=0 between edges → immediately RegWrite=0, busy_vec=0; after release mdu_ready=1 and no stale writes appear.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Brief    : Shared widths, write-back request type and register-zero index
//            for the register-file write-back path.
// Revision : 1.0 - initial release
// ============================================================================
package core_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NREG     = 32;   // 2**ADDR_W architectural registers
  localparam int REG_ZERO = 0;    // hard-wired zero register

  // One pending register-file write: destination and value.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Brief    : In-order FIFO for long-latency write-back results. Push is
//            ignored when full, pop is ignored when empty; the head entry is
//            presented combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
  import core_pkg::*;
#(
  parameter int  Q_DEPTH = 4,          // power of two, >= 2
  parameter type T       = wb_req_t
) (
  input  logic                         clk,
  input  logic                         rst,    // asynchronous, active-low
  input  logic                         push,
  input  T                             din,
  input  logic                         pop,
  output T                             head,
  output logic [$clog2(Q_DEPTH):0]     count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  T                   r_mem [Q_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_push_ok;
  logic               w_pop_ok;

  assign full      = (r_count == CNT_W'(Q_DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  // A full FIFO refuses a push even when it pops in the same cycle.
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  // Payload storage; contents are meaningless while not counted, so no reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/rf_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_writeback_arbiter
// Brief    : Register-file write port driver. ALU results win every cycle;
//            MDU/load results queue in a FIFO and drain when the ALU is idle.
//            Maintains the pending-write scoreboard used by decode.
// Revision : 1.0 - initial release
// ============================================================================
module rf_writeback_arbiter
  import core_pkg::*;
#(
  parameter int Q_DEPTH = 4            // MDU result queue depth, power of two
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active-low
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [ADDR_W-1:0] mdu_addr,
  input  logic [DATA_W-1:0] mdu_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic [NREG-1:0]   busy_vec,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] Write_addr,
  output logic [DATA_W-1:0] Write_data
);

  localparam int CNT_W = $clog2(Q_DEPTH) + 1;

  wb_req_t          w_mdu_req;
  wb_req_t          w_head;
  wb_req_t          w_sel_req;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_sel_any;
  logic [NREG-1:0]  w_busy_nxt;
  logic [NREG-1:0]  r_busy;
  logic             r_from_mdu;     // current write came from the FIFO

  assign w_mdu_req = '{addr: mdu_addr, data: mdu_data};
  assign mdu_ready = (w_count < CNT_W'(Q_DEPTH));
  assign w_push    = mdu_valid && !w_full;
  assign w_pop     = !alu_valid && !w_empty;
  assign w_sel_any = alu_valid || !w_empty;
  assign w_sel_req = alu_valid ? wb_req_t'{addr: alu_addr, data: alu_data} : w_head;
  assign busy_vec  = r_busy;

  wb_fifo #(
    .Q_DEPTH (Q_DEPTH),
    .T       (wb_req_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (w_mdu_req),
    .pop   (w_pop),
    .head  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // Register the selected write; address/data hold when nothing is selected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWrite   <= 1'b0;
      Write_addr <= '0;
      Write_data <= '0;
      r_from_mdu <= 1'b0;
    end else begin
      RegWrite   <= w_sel_any && (w_sel_req.addr != ADDR_W'(REG_ZERO));
      r_from_mdu <= w_pop && (w_head.addr != ADDR_W'(REG_ZERO));
      if (w_sel_any) begin
        Write_addr <= w_sel_req.addr;
        Write_data <= w_sel_req.data;
      end
    end
  end

  // Scoreboard update: clear on a FIFO-sourced write, then apply a new issue
  // so that a simultaneous set on the same register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (RegWrite && r_from_mdu) w_busy_nxt[Write_addr] = 1'b0;
    if (issue_valid && (issue_addr != ADDR_W'(REG_ZERO))) w_busy_nxt[issue_addr] = 1'b1;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_busy <= '0;
    else      r_busy <= w_busy_nxt;
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_writeback_arbiter
// Brief    : Directed, table-driven bench for rf_writeback_arbiter with
//            hand-written sequences for backpressure and mid-run reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_writeback_arbiter;
  import core_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mdu_valid;
  logic              mdu_ready;
  logic [ADDR_W-1:0] mdu_addr;
  logic [DATA_W-1:0] mdu_data;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_addr;
  logic [NREG-1:0]   busy_vec;
  logic              RegWrite;
  logic [ADDR_W-1:0] Write_addr;
  logic [DATA_W-1:0] Write_data;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        av;  logic [4:0] aa;  logic [31:0] ad;
    logic        mv;  logic [4:0] ma;  logic [31:0] md;
    logic        iv;  logic [4:0] ia;
    logic        erw; logic [4:0] ewa; logic [31:0] ewd;
    logic [31:0] ebusy; logic erdy;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  always #5 clk = ~clk;

  rf_writeback_arbiter #(.Q_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_addr    (alu_addr),
    .alu_data    (alu_data),
    .mdu_valid   (mdu_valid),
    .mdu_ready   (mdu_ready),
    .mdu_addr    (mdu_addr),
    .mdu_data    (mdu_data),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .busy_vec    (busy_vec),
    .RegWrite    (RegWrite),
    .Write_addr  (Write_addr),
    .Write_data  (Write_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic iv, input logic [4:0] ia);
    alu_valid = av;  alu_addr = aa;  alu_data = ad;
    mdu_valid = mv;  mdu_addr = ma;  mdu_data = md;
    issue_valid = iv; issue_addr = ia;
  endtask

  task automatic chk_out(input string tag, input logic rw, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [31:0] bz, input logic rdy);
    chk({tag, ".RegWrite"},   32'(RegWrite),   32'(rw));
    chk({tag, ".Write_addr"}, 32'(Write_addr), 32'(wa));
    chk({tag, ".Write_data"}, Write_data,      wd);
    chk({tag, ".busy_vec"},   busy_vec,        bz);
    chk({tag, ".mdu_ready"},  32'(mdu_ready),  32'(rdy));
  endtask

  initial begin
    int j;
    int acc_edge5;
    logic took;

    //        av aa   ad       mv ma  md        iv ia   rw wa   wd        busy    rdy
    tbl[0]  = '{1, 3, 'h11,    0, 0,  0,        0, 0,   1, 3,   'h11,     0,      1};
    tbl[1]  = '{1, 4, 'h22,    0, 0,  0,        0, 0,   1, 4,   'h22,     0,      1};
    tbl[2]  = '{0, 0, 0,       0, 0,  0,        0, 0,   0, 4,   'h22,     0,      1};
    tbl[3]  = '{0, 0, 0,       0, 0,  0,        1, 5,   0, 4,   'h22,     'h20,   1};
    tbl[4]  = '{0, 0, 0,       1, 5,  'hDEAD,   0, 0,   0, 4,   'h22,     'h20,   1};
    tbl[5]  = '{0, 0, 0,       0, 0,  0,        0, 0,   1, 5,   'hDEAD,   'h20,   1};
    tbl[6]  = '{0, 0, 0,       0, 0,  0,        0, 0,   0, 5,   'hDEAD,   0,      1};
    tbl[7]  = '{0, 0, 0,       0, 0,  0,        1, 7,   0, 5,   'hDEAD,   'h80,   1};
    tbl[8]  = '{0, 0, 0,       1, 7,  'h77,     0, 0,   0, 5,   'hDEAD,   'h80,   1};
    tbl[9]  = '{0, 0, 0,       0, 0,  0,        0, 0,   1, 7,   'h77,     'h80,   1};
    tbl[10] = '{0, 0, 0,       0, 0,  0,        1, 7,   0, 7,   'h77,     'h80,   1};
    tbl[11] = '{0, 0, 0,       1, 7,  'h78,     0, 0,   0, 7,   'h77,     'h80,   1};
    tbl[12] = '{0, 0, 0,       0, 0,  0,        0, 0,   1, 7,   'h78,     'h80,   1};
    tbl[13] = '{0, 0, 0,       0, 0,  0,        0, 0,   0, 7,   'h78,     0,      1};
    tbl[14] = '{1, 0, 'hFFFF,  1, 0,  'h1234,   1, 0,   0, 0,   'hFFFF,   0,      1};
    tbl[15] = '{0, 0, 0,       0, 0,  0,        0, 0,   0, 0,   'h1234,   0,      1};
    tbl[16] = '{1, 9, 'h99,    0, 0,  0,        0, 0,   1, 9,   'h99,     0,      1};
    tbl[17] = '{0, 0, 0,       0, 0,  0,        0, 0,   0, 9,   'h99,     0,      1};
    tbl[18] = '{0, 0, 0,       0, 0,  0,        1, 10,  0, 9,   'h99,     'h400,  1};
    tbl[19] = '{1, 10,'hAA,    0, 0,  0,        0, 0,   1, 10,  'hAA,     'h400,  1};
    tbl[20] = '{0, 0, 0,       0, 0,  0,        0, 0,   0, 10,  'hAA,     'h400,  1};
    tbl[21] = '{0, 0, 0,       1, 10, 'hAB,     0, 0,   0, 10,  'hAA,     'h400,  1};
    tbl[22] = '{0, 0, 0,       0, 0,  0,        0, 0,   1, 10,  'hAB,     'h400,  1};
    tbl[23] = '{0, 0, 0,       0, 0,  0,        0, 0,   0, 10,  'hAB,     0,      1};

    // Reset state
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk_out("reset", 0, 0, 0, 0, 1);

    // Table: inputs applied before an edge, outputs checked after it
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].mv, tbl[i].ma, tbl[i].md,
            tbl[i].iv, tbl[i].ia);
      @(negedge clk);
      chk_out($sformatf("vec%0d", i), tbl[i].erw, tbl[i].ewa, tbl[i].ewd,
              tbl[i].ebusy, tbl[i].erdy);
    end

    // Priority and backpressure: ALU busy for 6 edges, 5 MDU results offered
    j = 0;
    acc_edge5 = -1;
    for (int k = 0; k < 13; k++) begin
      drive(k < 6, 5'(20 + k), 32'(32'h100 + k),
            j < 5, 5'(11 + j), 32'(32'h1001 + j), 0, 0);
      took = mdu_valid && mdu_ready;
      @(negedge clk);
      if (took) begin
        j++;
        if (j == 5) acc_edge5 = k;
      end
      chk($sformatf("bp%0d.mdu_ready", k), 32'(mdu_ready), 32'((k >= 3 && k <= 5) ? 0 : 1));
      if (k < 6) begin
        chk($sformatf("bp%0d.RegWrite", k), 32'(RegWrite), 1);
        chk($sformatf("bp%0d.Write_addr", k), 32'(Write_addr), 32'(20 + k));
        chk($sformatf("bp%0d.Write_data", k), Write_data, 32'(32'h100 + k));
      end else if (k <= 10) begin
        chk($sformatf("bp%0d.RegWrite", k), 32'(RegWrite), 1);
        chk($sformatf("bp%0d.Write_addr", k), 32'(Write_addr), 32'(10 + k - 5));
        chk($sformatf("bp%0d.Write_data", k), Write_data, 32'(32'h1000 + k - 5));
      end else begin
        chk($sformatf("bp%0d.RegWrite", k), 32'(RegWrite), 0);
        chk($sformatf("bp%0d.Write_addr", k), 32'(Write_addr), 15);
      end
    end
    chk("bp.fifth_accept_edge", 32'(acc_edge5), 7);
    chk("bp.accepted", 32'(j), 5);

    // Reset mid-operation with three queued results and two pending bits
    drive(1, 1, 1, 1, 5, 'h55, 1, 5); @(negedge clk);
    drive(1, 1, 2, 1, 7, 'h57, 1, 7); @(negedge clk);
    drive(1, 1, 3, 1, 6, 'h56, 0, 0); @(negedge clk);
    chk("pre_rst.busy_vec", busy_vec, 32'hA0);
    chk("pre_rst.RegWrite", 32'(RegWrite), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("in_rst.RegWrite", 32'(RegWrite), 0);
    chk("in_rst.busy_vec", busy_vec, 0);
    chk("in_rst.Write_addr", 32'(Write_addr), 0);
    chk("in_rst.Write_data", Write_data, 0);
    #1 rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_out($sformatf("post_rst%0d", k), 0, 0, 0, 0, 1);
    end
    drive(1, 2, 5, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_out("post_rst_alu", 1, 2, 5, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
